// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - 3-stage pipelined floating-point multiplier with valid/ready handshake.
// Optional FMUL_ROUND_EN selects round-to-nearest-even; otherwise results truncate toward zero.
module fmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     A,
  input  logic [EXP_W+MAN_W:0]     B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     Result,
  output logic [3:0]               ALUFlags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // S1 combinational unpack/classify
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [EW-1:0] esum_c;

  assign {sa, ea, fa} = A;
  assign {sb, eb, fb} = B;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) & (fa == '0);
  assign b_inf  = (&eb) & (fb == '0);
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign esum_c = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [EW-1:0] s1_esum;
  logic [MAN_W:0]       s1_ma, s1_mb;
  logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
  logic signed [EW-1:0] s2_esum;
  logic [PW-1:0]        s2_prod;

  // S3 combinational normalise/round/pack
  logic                 msb, guard, sticky, inc, inexact;
  logic [PW-2:0]        norm;
  logic [MAN_W:0]       mant_r;
  logic signed [EW-1:0] e_fin;
  logic [W-1:0]         res_c;
  logic [3:0]           flg_c;

  always_comb begin
    msb    = s2_prod[PW-1];
    norm   = msb ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    guard  = norm[PW-2-MAN_W];
    sticky = |norm[PW-3-MAN_W:0];
    inc    = 1'b0;
`ifdef FMUL_ROUND_EN
    inc    = guard & (sticky | norm[PW-1-MAN_W]);
`endif
    mant_r  = {1'b0, norm[PW-2 -: MAN_W]} + {{MAN_W{1'b0}}, inc};
    e_fin   = s2_esum + $signed({{(EW-1){1'b0}}, msb})
                      + $signed({{(EW-1){1'b0}}, mant_r[MAN_W]});
    inexact = guard | sticky;
    res_c   = {s2_sign, e_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
    flg_c   = {s2_sign, 1'b0, inexact, 1'b0};
    if (s2_nan) begin
      res_c = QNAN;
      flg_c = 4'b0000;
    end else if (s2_inf) begin
      res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_c = {s2_sign, 3'b000};
    end else if (s2_zero) begin
      res_c = {s2_sign, {(W-1){1'b0}}};
      flg_c = {s2_sign, 3'b100};
    end else if (e_fin >= EMAX) begin
      res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_c = {s2_sign, 3'b011};
    end else if (e_fin[EW-1] || e_fin == '0) begin
      res_c = {s2_sign, {(W-1){1'b0}}};
      flg_c = {s2_sign, 3'b110};
    end
  end

  // Every stage moves together on advance so bubbles travel like data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_esum   <= '0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_esum   <= '0;
      s2_prod   <= '0;
      out_valid <= 1'b0;
      Result    <= '0;
      ALUFlags  <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_sign   <= sa ^ sb;
      s1_nan    <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_inf    <= a_inf | b_inf;
      s1_zero   <= a_zero | b_zero;
      s1_esum   <= esum_c;
      s1_ma     <= {1'b1, fa};
      s1_mb     <= {1'b1, fb};
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_esum   <= s1_esum;
      s2_prod   <= PW'(s1_ma) * PW'(s1_mb);
      out_valid <= s2_valid;
      Result    <= res_c;
      ALUFlags  <= flg_c;
    end
  end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb/tb_fmul_pipe.sv - randomized and directed bench for fmul_pipe against a reference model.
module tb_fmul_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] sb_q[$];

  always #5 clk = ~clk;

  fmul_pipe dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .Result(result), .ALUFlags(flags)
  );

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, rounding decided by comparing the remainder to half an ulp.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    logic s, inexact, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, big;
    longint unsigned p, keep, rem, half;
    int e, sh;
    s      = x[31] ^ y[31];
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
      return {4'b0000, 32'h7FC00000};
    if (x_inf || y_inf) return {s, 3'b000, s, 8'hFF, 23'h0};
    if (x_zero || y_zero) return {s, 3'b100, s, 31'h0};
    p    = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    e    = int'(x[30:23]) + int'(y[30:23]) - 127;
    big  = (p >> 47) != 0;
    sh   = big ? 24 : 23;
    e    = e + (big ? 1 : 0);
    keep = p >> sh;
    rem  = p - (keep << sh);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 0);
`ifdef FMUL_ROUND_EN
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
`endif
    if (keep == (64'd1 << 24)) begin
      keep = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {s, 3'b011, s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 3'b110, s, 31'h0};
    return {s, 1'b0, inexact, 1'b0, s, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 9))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 60));
      3:       e = 8'($urandom_range(190, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    m = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [35:0] exp);
    int cnt;
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_rdy"}, 36'(in_ready), 36'(1));
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && cnt < 10) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 36'(cnt), 36'(3));
    check(tag, {flags, result}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ops_a[3], ops_b[3];
    logic [35:0] exp_r[3];
    int drained;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 36'(out_valid), 36'(0));
    check("rst_result", {flags, result}, 36'h0);
    rst_n = 1'b1;

    run_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});
    run_op("mul_neg", 32'hC0000000, 32'h40400000, {4'b1000, 32'hC0C00000});
    run_op("overflow", 32'h7F000000, 32'h40000000, {4'b0011, 32'h7F800000});
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, {4'b0000, 32'h7FC00000});
    run_op("underflow", 32'h00800000, 32'h00800000, {4'b0110, 32'h00000000});
`ifdef FMUL_ROUND_EN
    run_op("rounding", 32'h3FC00001, 32'h3FC00000, {4'b0010, 32'h40100001});
`else
    run_op("rounding", 32'h3FC00001, 32'h3FC00000, {4'b0010, 32'h40100000});
`endif
    run_op("nan_in", 32'hFFC12345, 32'h3F800000, {4'b0000, 32'h7FC00000});
    run_op("inf_x_neg", 32'h7F800000, 32'hC0000000, {4'b1000, 32'hFF800000});
    run_op("zero_x_neg", 32'h00000000, 32'hC0400000, {4'b1100, 32'h80000000});

    // Backpressure: three ops back to back, consumer stalled for five cycles.
    for (int i = 0; i < 3; i++) begin
      ops_a[i] = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
      ops_b[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      exp_r[i] = model(ops_a[i], ops_b[i]);
    end
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = ops_a[i]; b = ops_b[i]; in_valid = 1'b1;
      #1 check("bp_accept", 36'(in_ready), 36'(1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_in_ready", 36'(in_ready), 36'(0));
      check("bp_hold", {flags, result}, exp_r[0]);
      check("bp_valid", 36'(out_valid), 36'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_drain_valid", 36'(out_valid), 36'(1));
      check("bp_drain", {flags, result}, exp_r[i]);
      @(negedge clk);
    end
    #1 check("bp_empty", 36'(out_valid), 36'(0));

    // Asynchronous reset with ops in flight.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = ops_a[i]; b = ops_b[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("arst_valid", 36'(out_valid), 36'(0));
    check("arst_result", {flags, result}, 36'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});

    // Randomized traffic with random stalls, scoreboard in order.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rand_op();
      b         = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
      #1 check("rnd_in_ready", 36'(in_ready), 36'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("rnd_spurious", 36'(out_valid), 36'(0));
        else check("rnd_result", {flags, result}, sb_q.pop_front());
      end
      if (in_valid && in_ready) sb_q.push_back(model(a, b));
    end
    in_valid  = 1'b0;
    drained   = 0;
    while (sb_q.size() != 0 && drained < 20) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) check("drain_result", {flags, result}, sb_q.pop_front());
      drained++;
    end
    check("drain_empty", 36'(sb_q.size()), 36'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
